p2s_stream: RTL

- Parametrised parallel-to-serial converter with valid/ready handshakes on both sides.
- Generalises single-bit serialisation to W-bit beats, with selectable bit order and an end-of-word marker.
- A one-entry holding register lets the next parallel word be accepted while the current word shifts, giving zero-bubble back-to-back throughput.
- Sits between a parallel producer (bus/FIFO) and a narrow serial link or transmitter.

---
 rtl/p2s_stream.sv | 108 ++++++++++
 1 files changed

// File: rtl/p2s_stream.sv
// Parallel-to-serial converter: N-bit words in, W-bit beats out, valid/ready on both
// sides, with a one-word holding register so consecutive words stream with no gap.
module p2s_stream #(
    parameter int N         = 8,
    parameter int W         = 1,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         par_valid,
    output logic         par_ready,
    input  logic [N-1:0] par_data,
    input  logic         ser_ready,
    output logic         ser_valid,
    output logic [W-1:0] ser_data,
    output logic         ser_last
);
    localparam int            BEATS    = N / W;
    localparam int            CW       = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(BEATS - 1);

    if (N < 1 || W < 1 || (N % W) != 0) begin : g_bad_param
        $error("p2s_stream: N must be a positive multiple of W");
    end

    // Encoding is {sh_valid, hold_valid}; the hold slot only fills behind a busy shifter.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_SHIFT = 2'b10,
        ST_FULL  = 2'b11
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  sh_q, sh_d;
    logic [N-1:0]  hold_q, hold_d;
    logic [CW-1:0] count_q, count_d;

    logic sh_valid, hold_valid;
    logic par_fire, ser_fire, last_fire, slot_open;

    assign sh_valid   = state_q[1];
    assign hold_valid = state_q[0];

    assign par_ready = !hold_valid;
    assign ser_valid = sh_valid;
    assign ser_last  = sh_valid && (count_q == LAST_CNT);

    assign par_fire  = par_valid && par_ready;
    assign ser_fire  = ser_valid && ser_ready;
    assign last_fire = ser_fire && ser_last;
    assign slot_open = !sh_valid || last_fire;

    // Beats are picked by index rather than shifted, so the register stays put under backpressure.
    logic [W-1:0] beat [BEATS];
    for (genvar k = 0; k < BEATS; k++) begin : g_beat
        assign beat[k] = LSB_FIRST ? sh_q[k*W +: W] : sh_q[N-1-k*W -: W];
    end

    if (BEATS == 1) begin : g_single
        assign ser_data = beat[0];
    end else begin : g_multi
        assign ser_data = beat[count_q];
    end

    always_comb begin
        // NOTE: every variable driven here gets a default first, so no path can infer a latch.
        state_d = state_q;
        sh_d    = sh_q;
        hold_d  = hold_q;
        count_d = count_q;
        if (slot_open) begin
            count_d = '0;
            if (hold_valid) begin
                sh_d    = hold_q;
                state_d = ST_SHIFT;
            end else if (par_fire) begin
                sh_d    = par_data;
                state_d = ST_SHIFT;
            end else begin
                state_d = ST_EMPTY;
            end
        end else begin
            if (ser_fire) begin
                count_d = count_q + 1'b1;
            end
            if (par_fire) begin
                hold_d  = par_data;
                state_d = ST_FULL;
            end
        end
    end

    // NOTE: data registers are reset as well, so ser_data reads zero straight out of reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_EMPTY;
            sh_q    <= '0;
            hold_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            hold_q  <= hold_d;
            count_q <= count_d;
        end
    end

endmodule
